// File: rtl/dram_burst_mc.sv
// Multi-channel DRAM burst model: one write port plus NUM_RD round-robin read channels.
// Bursts are issued one beat per cycle and delivered after a fixed RD_LATENCY.
module dram_burst_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_RD     = 2,
    parameter int RD_LATENCY = 2,
    parameter int BURST_MAX  = 16,
    parameter int LW         = $clog2(BURST_MAX) + 1
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         en_wr,
    input  logic [ADDR_WIDTH-1:0]        addr_wr,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [NUM_RD-1:0]            en_rd,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] addr_rd,
    input  logic [NUM_RD*LW-1:0]         len_rd,
    output logic [NUM_RD-1:0]            rd_ack,
    output logic [NUM_RD-1:0]            valid,
    output logic                         last,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         busy
);
    localparam int PW    = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {IDLE, BURST} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         cur_ch;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LW-1:0]         beats_left;

    logic [NUM_RD-1:0]     pipe_ch   [RD_LATENCY];
    logic                  pipe_last [RD_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_data [RD_LATENCY];

    logic                  issue;
    logic                  last_issue;
    logic                  can_grant;
    logic                  grant;
    logic [PW-1:0]         grant_ch;
    logic [NUM_RD-1:0]     req;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [LW-1:0]         raw_len;
    logic [LW-1:0]         grant_len;
    logic [NUM_RD-1:0]     issue_onehot;
    logic                  pipe_busy;

    assign issue      = (state == BURST);
    assign last_issue = issue && (beats_left == LW'(1));
    assign can_grant  = (state == IDLE) || last_issue;

    // Request handshake: a channel holds en_rd/addr/len stable until it sees its
    // rd_ack pulse and drops en_rd in that same cycle; the acked channel is masked
    // so a single-beat burst cannot be granted twice off one request.
    assign req = can_grant ? (en_rd & ~rd_ack) : '0;

    always_comb begin
        int idx;
        grant    = 1'b0;
        grant_ch = '0;
        idx      = 0;
        for (int i = 1; i <= NUM_RD; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_RD;
            if (!grant && req[idx]) begin
                grant    = 1'b1;
                grant_ch = PW'(idx);
            end
        end
    end

    assign grant_addr = addr_rd[int'(grant_ch)*ADDR_WIDTH +: ADDR_WIDTH];
    assign raw_len    = len_rd[int'(grant_ch)*LW +: LW];
    assign grant_len  = (raw_len == '0)              ? LW'(1) :
                        (raw_len > LW'(BURST_MAX))   ? LW'(BURST_MAX) : raw_len;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            rr_ptr     <= PW'(NUM_RD - 1);
            cur_ch     <= '0;
            cur_addr   <= '0;
            beats_left <= '0;
            rd_ack     <= '0;
        end else begin
            rd_ack <= '0;
            if (issue) begin
                cur_addr   <= cur_addr + ADDR_WIDTH'(1);
                beats_left <= beats_left - LW'(1);
            end
            // A grant in the last issue cycle chains straight into the next burst.
            if (grant) begin
                state      <= BURST;
                rr_ptr     <= grant_ch;
                cur_ch     <= grant_ch;
                cur_addr   <= grant_addr;
                beats_left <= grant_len;
                rd_ack     <= NUM_RD'(1) << grant_ch;
            end else if (last_issue) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en_wr) begin
            mem[addr_wr] <= data_in;
        end
    end

    assign issue_onehot = issue ? (NUM_RD'(1) << cur_ch) : '0;

    // Array is read at issue; data registers only move with a valid beat so
    // data_out keeps the last delivered word between bursts.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_ch[i]   <= '0;
                pipe_last[i] <= 1'b0;
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_ch[0]   <= issue_onehot;
            pipe_last[0] <= last_issue;
            if (issue) begin
                pipe_data[0] <= mem[cur_addr];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_ch[i]   <= pipe_ch[i-1];
                pipe_last[i] <= pipe_last[i-1];
                if (|pipe_ch[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_busy = pipe_busy | (|pipe_ch[i]);
        end
    end

    assign valid    = pipe_ch[RD_LATENCY-1];
    assign last     = pipe_last[RD_LATENCY-1];
    assign data_out = pipe_data[RD_LATENCY-1];
    assign busy     = issue || pipe_busy;

endmodule

// File: tb/tb_dram_burst_mc.sv
// Bench for dram_burst_mc: directed scenarios plus randomized traffic against a
// transaction-level schedule model of grants, beats and memory contents.
module tb_dram_burst_mc;
    localparam int DW    = 32;
    localparam int AW    = 18;
    localparam int NR    = 2;
    localparam int RL    = 2;
    localparam int BM    = 16;
    localparam int LW    = $clog2(BM) + 1;
    localparam int DEPTH = 1 << AW;

    logic           clk;
    logic           arst;
    logic           en_wr;
    logic [AW-1:0]  addr_wr;
    logic [DW-1:0]  data_in;
    logic [NR-1:0]  en_rd;
    logic [NR*AW-1:0] addr_rd;
    logic [NR*LW-1:0] len_rd;
    logic [NR-1:0]  rd_ack;
    logic [NR-1:0]  valid;
    logic           last;
    logic [DW-1:0]  data_out;
    logic           busy;

    dram_burst_mc #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .RD_LATENCY(RL), .BURST_MAX(BM)
    ) dut (
        .clk(clk), .arst(arst), .en_wr(en_wr), .addr_wr(addr_wr), .data_in(data_in),
        .en_rd(en_rd), .addr_rd(addr_rd), .len_rd(len_rd), .rd_ack(rd_ack),
        .valid(valid), .last(last), .data_out(data_out), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    typedef struct { logic [AW-1:0] addr; logic [LW-1:0] len; } req_t;
    typedef struct { int issue_cyc; int deliver_cyc; int ch; bit lst; logic [AW-1:0] addr; logic [DW-1:0] data; } beat_t;
    typedef struct { int cyc; int ch; bit lst; logic [DW-1:0] data; } obs_t;
    typedef struct { int cyc; int ch; } ack_t;

    req_t  req_q [NR][$];
    beat_t pend[$];
    beat_t exp_q[$];
    obs_t  obs_q[$];
    ack_t  ack_q[$];

    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] data_hold;
    logic [NR-1:0] ack_next;
    int cyc;
    int issue_end;
    int rr_ptr_m;
    int raise_cyc [NR];
    bit rand_wr;
    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit any_req();
        for (int c = 0; c < NR; c++) begin
            if (req_q[c].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push_req(input int ch, input int addr, input int len);
        req_t r;
        r.addr = AW'(addr);
        r.len  = LW'(len);
        req_q[ch].push_back(r);
    endtask

    task automatic model_reset();
        pend.delete();
        exp_q.delete();
        issue_end = -1;
        rr_ptr_m  = NR - 1;
        ack_next  = '0;
        data_hold = '0;
    endtask

    // Reference: engine may accept a request once its previous burst is on its
    // last issue cycle; beats read memory at issue, before that cycle's write.
    task automatic model_cycle();
        beat_t b;
        int c;
        int len;
        int blen;
        logic [AW-1:0] a;
        while (pend.size() > 0 && pend[0].issue_cyc == cyc) begin
            b = pend.pop_front();
            b.data = ref_mem[b.addr];
            exp_q.push_back(b);
        end
        ack_next = '0;
        if (cyc >= issue_end) begin
            for (int i = 1; i <= NR; i++) begin
                c = (rr_ptr_m + i) % NR;
                if (ack_next == '0 && en_rd[c]) begin
                    len  = int'(len_rd[c*LW +: LW]);
                    blen = (len == 0) ? 1 : ((len > BM) ? BM : len);
                    a    = addr_rd[c*AW +: AW];
                    for (int k = 0; k < blen; k++) begin
                        b.issue_cyc   = cyc + 1 + k;
                        b.deliver_cyc = cyc + 1 + k + RL;
                        b.ch          = c;
                        b.lst         = (k == blen - 1);
                        b.addr        = a + AW'(k);
                        b.data        = '0;
                        pend.push_back(b);
                    end
                    issue_end = cyc + blen;
                    rr_ptr_m  = c;
                    ack_next  = NR'(1) << c;
                end
            end
        end
        if (en_wr) ref_mem[addr_wr] = data_in;
    endtask

    // ---------------- driver + scoreboard, one clock cycle ----------------
    task automatic step();
        req_t r;
        beat_t b;
        obs_t o;
        ack_t ak;
        logic [NR-1:0] v_exp;
        bit l_exp;
        bit b_exp;
        for (int c = 0; c < NR; c++) begin
            if (en_rd[c] && rd_ack[c]) begin
                en_rd[c] = 1'b0;
            end else if (!en_rd[c] && !rd_ack[c] && req_q[c].size() > 0) begin
                r = req_q[c].pop_front();
                en_rd[c] = 1'b1;
                addr_rd[c*AW +: AW] = r.addr;
                len_rd[c*LW +: LW]  = r.len;
                raise_cyc[c] = cyc;
            end
        end
        if (rand_wr) begin
            en_wr   = ($urandom_range(0, 3) == 0);
            addr_wr = AW'($urandom_range(0, 63));
            data_in = $urandom;
        end
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
        v_exp = '0;
        l_exp = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].deliver_cyc == cyc) begin
            b = exp_q.pop_front();
            v_exp = NR'(1) << b.ch;
            l_exp = b.lst;
            data_hold = b.data;
        end
        b_exp = (pend.size() > 0 && pend[0].issue_cyc <= cyc) || exp_q.size() > 0 || v_exp != '0;
        check("rd_ack", rd_ack, ack_next);
        check("valid", valid, v_exp);
        check("last", last, l_exp);
        check("data_out", data_out, data_hold);
        check("busy", busy, b_exp);
        if (valid != '0) begin
            o.cyc = cyc; o.ch = oh_idx(valid); o.lst = last; o.data = data_out;
            obs_q.push_back(o);
        end
        if (rd_ack != '0) begin
            ak.cyc = cyc; ak.ch = oh_idx(rd_ack);
            ack_q.push_back(ak);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && (pend.size() > 0 || exp_q.size() > 0 || any_req() || en_rd != '0 || ack_next != '0)) begin
            step();
            n++;
        end
        check("drain_bound", 64'(n < budget), 64'(1));
        step();
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        n_vec = 0; n_err = 0; cyc = 0; rand_wr = 1'b0;
        arst = 1'b1; en_wr = 1'b0; addr_wr = '0; data_in = '0;
        en_rd = '0; addr_rd = '0; len_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dut.mem[i] = DW'(i);
            ref_mem[i] = DW'(i);
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_ack", rd_ack, 0);
        check("rst_valid", valid, 0);
        check("rst_last", last, 0);
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);
        @(negedge clk) arst = 1'b0;

        // Contested round robin: ch0 first after reset, then strict alternation.
        obs_q.delete(); ack_q.delete();
        for (int k = 0; k < 3; k++) begin
            push_req(0, 200 + 10*k, 2);
            push_req(1, 300 + 10*k, 2);
        end
        drain(200);
        check("rr_grants", ack_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < ack_q.size()) check("rr_order", ack_q[i].ch, i % 2);
        end
        check("rr_beats", obs_q.size(), 12);
        if (obs_q.size() == 12) begin
            check("rr_contig", obs_q[11].cyc - obs_q[0].cyc, 11);
            check("rr_first_data", obs_q[0].data, 200);
            check("rr_second_burst", obs_q[2].data, 300);
        end

        // Single burst: ack latency, data values, last flag.
        obs_q.delete(); ack_q.delete();
        push_req(0, 100, 4);
        drain(100);
        check("b1_acks", ack_q.size(), 1);
        if (ack_q.size() > 0) check("b1_ack_lat", ack_q[0].cyc - raise_cyc[0], 1);
        check("b1_beats", obs_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < obs_q.size()) begin
                check("b1_data", obs_q[k].data, 100 + k);
                check("b1_last", obs_q[k].lst, k == 3);
                check("b1_ch", obs_q[k].ch, 0);
            end
        end

        // Address wrap at the top of memory.
        obs_q.delete();
        push_req(1, DEPTH - 2, 4);
        drain(100);
        check("wrap_beats", obs_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < obs_q.size()) check("wrap_data", obs_q[k].data, (DEPTH - 2 + k) % DEPTH);
        end

        // Write to the address being issued this cycle: old data, then new.
        obs_q.delete();
        push_req(0, 5, 1);
        n = 0;
        while (rd_ack[0] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("coll_ack_seen", rd_ack[0], 1);
        en_wr = 1'b1; addr_wr = AW'(5); data_in = 32'hDEADBEEF;
        step();
        en_wr = 1'b0;
        drain(50);
        check("coll_beats", obs_q.size(), 1);
        if (obs_q.size() > 0) check("coll_old", obs_q[0].data, 5);
        obs_q.delete();
        push_req(1, 5, 1);
        drain(50);
        check("coll_new_beats", obs_q.size(), 1);
        if (obs_q.size() > 0) check("coll_new", obs_q[0].data, 32'hDEADBEEF);

        // Length 0 and over-long bursts.
        obs_q.delete();
        push_req(0, 400, 0);
        drain(50);
        check("len0_beats", obs_q.size(), 1);
        if (obs_q.size() > 0) check("len0_last", obs_q[0].lst, 1);
        obs_q.delete();
        push_req(1, 500, BM + 5);
        drain(100);
        check("lenmax_beats", obs_q.size(), BM);
        if (obs_q.size() == BM) begin
            check("lenmax_last", obs_q[BM-1].lst, 1);
            check("lenmax_notlast", obs_q[BM-2].lst, 0);
            check("lenmax_data", obs_q[BM-1].data, 500 + BM - 1);
        end

        // Asynchronous reset after two of eight beats.
        obs_q.delete();
        push_req(0, 3000, 8);
        n = 0;
        while (obs_q.size() < 2 && n < 40) begin
            step();
            n++;
        end
        check("rstmid_two_beats", obs_q.size(), 2);
        #2 arst = 1'b1;
        #1;
        check("rstmid_rd_ack", rd_ack, 0);
        check("rstmid_valid", valid, 0);
        check("rstmid_last", last, 0);
        check("rstmid_data", data_out, 0);
        check("rstmid_busy", busy, 0);
        model_reset();
        en_rd = '0;
        for (int c = 0; c < NR; c++) req_q[c].delete();
        @(posedge clk);
        @(negedge clk) arst = 1'b0;
        obs_q.delete();
        repeat (12) step();
        check("rstmid_no_valid", obs_q.size(), 0);
        obs_q.delete(); ack_q.delete();
        push_req(0, 3000, 8);
        push_req(1, 4000, 2);
        drain(100);
        if (ack_q.size() > 0) check("rstmid_first_grant", ack_q[0].ch, 0);
        check("rstmid_beats", obs_q.size(), 10);
        for (int k = 0; k < 8; k++) begin
            if (k < obs_q.size()) check("rstmid_mem", obs_q[k].data, 3000 + k);
        end

        // Randomized traffic with concurrent writes into the read window.
        rand_wr = 1'b1;
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 7) == 0)
                    push_req($urandom_range(0, NR - 1), DEPTH - 1 - $urandom_range(0, 20), $urandom_range(0, BM + 4));
                else
                    push_req($urandom_range(0, NR - 1), $urandom_range(0, 63), $urandom_range(0, BM + 4));
            end
            step();
        end
        rand_wr = 1'b0;
        en_wr = 1'b0;
        drain(2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
